// File: rtl/tdm_demux16.sv
// Receive-side TDM demultiplexer: collects NCH time-slotted samples into a work
// buffer and publishes each complete, consecutively filled frame as one parallel word.
module tdm_demux16 #(
    parameter int WIDTH = 1,
    parameter int NCH   = 16,
    parameter int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [CW-1:0]        slot_idx
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);

    // Handshake: din/frame_sync are consumed on every rising edge where din_valid=1;
    // there is no back-pressure, and dout_valid is a one-cycle "dout just changed" pulse.
    state_t                 state_q, state_d;
    logic [CW-1:0]          slot_q, slot_d;
    logic [NCH*WIDTH-1:0]   work_q, work_d;
    logic [NCH*WIDTH-1:0]   dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            work_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            work_q       <= work_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        work_d       = work_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        work_d[0 +: WIDTH] = din;
                        slot_d             = CW'(1);
                        state_d            = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == '0) begin
                        if (frame_sync) begin
                            work_d[0 +: WIDTH] = din;
                            slot_d             = CW'(1);
                        end else begin
                            sync_err_d = 1'b1;
                            slot_d     = '0;
                            state_d    = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early marker: abandon the partial frame and start over at slot 1.
                        sync_err_d         = 1'b1;
                        work_d[0 +: WIDTH] = din;
                        slot_d             = CW'(1);
                    end else begin
                        work_d[int'(slot_q)*WIDTH +: WIDTH] = din;
                        slot_d                              = slot_q + CW'(1);
                        if (slot_q == LAST_SLOT) begin
                            dout_d       = work_d;
                            dout_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sync_err   = sync_err_q;
    assign slot_idx   = slot_q;
    assign locked     = (state_q == LOCKED);

endmodule
